// File: rtl/vec_pkg.sv
// Shared types and per-lane pixel reduction for the vector writeback packer.
// VEC_WB_SAT_EN selects unsigned-byte clamping; otherwise lanes are truncated.
package vec_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vec_wb_state_t;

  function automatic logic [PIX_W-1:0] sat_u8(input logic [LANE_W-1:0] v);
`ifdef VEC_WB_SAT_EN
    if (v[LANE_W-1])
      sat_u8 = '0;
    else if (|v[LANE_W-2:PIX_W])
      sat_u8 = '1;
    else
      sat_u8 = v[PIX_W-1:0];
`else
    sat_u8 = v[PIX_W-1:0];
`endif
  endfunction

  // True when a signed lane lies outside 0..255.
  function automatic logic lane_clamped(input logic [LANE_W-1:0] v);
    lane_clamped = v[LANE_W-1] | (|v[LANE_W-2:PIX_W]);
  endfunction

endpackage

// File: rtl/vec_wb_fifo.sv
// Synchronous FIFO of packed pixel words; head is read straight from storage.
module vec_wb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/vec_wb_packer.sv
// Vector ALU writeback: reduces lanes to pixels, packs, buffers and writes words
// to auto-incrementing addresses. Define VEC_WB_SAT_EN for clamping and sat_flag.
module vec_wb_packer
  import vec_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         word_count,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   in_data,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [PIX_W*LANES-1:0]    mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      sat_flag
);

  localparam int unsigned WORD_W = PIX_W * LANES;

  vec_wb_state_t     state;
  vec_wb_state_t     state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [WORD_W-1:0] packed_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              run_start;

  assign run_start = (state == IDLE) && start;
  assign in_ready  = (state == RUN) && !fifo_full && (acc_cnt < count_q);
  assign push      = in_valid && in_ready;
  assign mem_we    = !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = base_q + wr_cnt;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < int'(LANES); i++)
      packed_word[i*PIX_W +: PIX_W] = sat_u8(in_data[i*LANE_W +: LANE_W]);
  end

  vec_wb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (packed_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Transitions look ahead one edge so done follows the last pop directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if ((acc_cnt == count_q) || (push && ((acc_cnt + ADDR_W'(1)) == count_q)))
               state_nxt = DRAIN;
      DRAIN: if ((wr_cnt == count_q) || (pop && ((wr_cnt + ADDR_W'(1)) == count_q)))
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      count_q <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (run_start) begin
      base_q  <= base_addr;
      count_q <= word_count;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push)
        acc_cnt <= acc_cnt + ADDR_W'(1);
      if (pop)
        wr_cnt <= wr_cnt + ADDR_W'(1);
    end
  end

`ifdef VEC_WB_SAT_EN
  logic clamp_any;

  always_comb begin
    clamp_any = 1'b0;
    for (int i = 0; i < int'(LANES); i++)
      clamp_any = clamp_any | lane_clamped(in_data[i*LANE_W +: LANE_W]);
  end

  // Sticky for the run; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_flag <= 1'b0;
    else if (run_start)
      sat_flag <= 1'b0;
    else if (push && clamp_any)
      sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_vec_wb_packer.sv
// Directed self-checking bench for vec_wb_packer (default LANES=4, DEPTH=4, ADDR_W=16).
module tb_vec_wb_packer;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 16;
`ifdef VEC_WB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [15:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [127:0]  in_data = '0;
  logic          mem_ready = 1'b0;
  logic          in_ready, mem_we, busy, done, sat_flag;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_wdata;

  vec_wb_packer #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge; the only writer of these.
  int push_cnt = 0, we_seen = 0, in_ready_seen = 0, done_cnt = 0;
  int done_cyc = 0, last_pop_cyc = 0, run_push_cyc = 0, run_we_cyc = 0;
  logic [31:0] run_we_data = '0;
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int pb = 0, wb = 0, ib = 0, db = 0, qb = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (push_cnt == pb) run_push_cyc = cyc;
        push_cnt++;
      end
      if (in_ready) in_ready_seen++;
      if (mem_we) begin
        if (we_seen == wb) begin run_we_cyc = cyc; run_we_data = mem_wdata; end
        we_seen++;
      end
      if (mem_we && mem_ready) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
        last_pop_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  function automatic logic [127:0] mk(input int l0, input int l1, input int l2, input int l3);
    mk = {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  function automatic logic [127:0] pattern(input int k);
    pattern = mk(4*k+1, 4*k+2, 4*k+3, 4*k+4);
  endfunction

  function automatic logic [31:0] pword(input int k);
    pword = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int snap_push = 0;
  logic snap_in_ready = 1'b0, snap_we = 1'b0;
  logic [31:0] snap_wdata = '0;
  logic [15:0] snap_addr = '0;

  // One run: mem_ready low for the first `low` cycles; optional start pulses while busy.
  task automatic run(input logic [15:0] b, input logic [15:0] n, input bit cst,
                     input logic [127:0] cd, input int low, input bit spam);
    bit finished = 1'b0;
    pb = push_cnt; wb = we_seen; ib = in_ready_seen; db = done_cnt; qb = wa_q.size();
    base_addr = b; word_count = n; start = 1'b1; in_valid = 1'b1;
    mem_ready = (low == 0);
    in_data = cst ? cd : pattern(0);
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && !finished; i++) begin
      if (done_cnt != db) begin
        finished = 1'b1;
      end else begin
        if (i == low) begin
          snap_push = push_cnt - pb; snap_in_ready = in_ready; snap_we = mem_we;
          snap_wdata = mem_wdata; snap_addr = mem_addr;
        end
        mem_ready = (i >= low);
        in_data = cst ? cd : pattern(push_cnt - pb);
        if (spam) begin
          start = (i % 3 == 1);
          base_addr = 16'hDEAD;
          word_count = 16'd9;
        end
        step();
      end
    end
    start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    check("run_completes", 32'(finished), 32'd1);
    repeat (3) step();
  endtask

  task automatic verify(input string nm, input logic [15:0] b, input int n, input bit cst,
                        input logic [31:0] cw, input logic sat_e);
    check({nm, "_writes"}, 32'(wa_q.size() - qb), 32'(n));
    for (int k = 0; k < n && qb + k < wa_q.size(); k++) begin
      check({nm, "_addr"}, 32'(wa_q[qb+k]), 32'(16'(b + 16'(k))));
      check({nm, "_data"}, wd_q[qb+k], cst ? cw : pword(k));
    end
    check({nm, "_done_count"}, 32'(done_cnt - db), 32'd1);
    if (n > 0)
      check({nm, "_done_after_last_pop"}, 32'(done_cyc), 32'(last_pop_cyc + 1));
    else
      check({nm, "_done_3_after_start"}, 32'(done_cyc), 32'(start_cyc + 3));
    check({nm, "_sat_flag"}, 32'(sat_flag), 32'(sat_e));
    check({nm, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    string        name;
    logic [127:0] data;
    logic [31:0]  trunc_word;
    logic [31:0]  sat_word;
    logic         sat_exp;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [127:0] d, input logic [31:0] t,
                               input logic [31:0] s, input logic f);
    mkv.name = nm; mkv.data = d; mkv.trunc_word = t; mkv.sat_word = s; mkv.sat_exp = f;
  endfunction

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mkv("in_range",  mk(10, 20, 30, 40),   32'h281E140A, 32'h281E140A, 1'b0);
    tbl[1] = mkv("mixed_oor", mk(-5, 300, 255, 0),  32'h00FF2CFB, 32'h00FFFF00, 1'b1);
    tbl[2] = mkv("edges",     mk(0, 255, 128, 1),   32'h0180FF00, 32'h0180FF00, 1'b0);
    tbl[3] = mkv("big_neg",   mk(256, -1, -256, 32'h7FFFFFFF), 32'hFF00FF00, 32'hFF0000FF, 1'b1);
    tbl[4] = mkv("min_int",   mk(int'(32'h80000000), 511, 254, 7), 32'h07FEFF00, 32'h07FEFF00, 1'b1);

    // Reset values.
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic three-word run at full memory rate.
    run(16'h0100, 16'd3, 1'b1, mk(10, 20, 30, 40), 0, 1'b0);
    verify("basic", 16'h0100, 3, 1'b1, 32'h281E140A, 1'b0);
    check("basic_latency", 32'(run_we_cyc), 32'(run_push_cyc + 1));
    check("basic_pushes", 32'(push_cnt - pb), 32'd3);

    // Lane reduction table, one word per run.
    for (int i = 0; i < 5; i++) begin
      run(16'h0200 + 16'(i), 16'd1, 1'b1, tbl[i].data, 0, 1'b0);
      verify(tbl[i].name, 16'h0200 + 16'(i), 1, 1'b1,
             SAT ? tbl[i].sat_word : tbl[i].trunc_word, SAT ? tbl[i].sat_exp : 1'b0);
    end

    // Memory stalled for 10 cycles: FIFO fills, head holds, then all six drain in order.
    run(16'h0400, 16'd6, 1'b0, '0, 10, 1'b0);
    check("stall_pushes_at_full", 32'(snap_push), 32'd4);
    check("stall_in_ready", 32'(snap_in_ready), 32'd0);
    check("stall_mem_we", 32'(snap_we), 32'd1);
    check("stall_head_first", run_we_data, pword(0));
    check("stall_head_held", snap_wdata, pword(0));
    check("stall_addr_held", 32'(snap_addr), 32'h0400);
    verify("stall", 16'h0400, 6, 1'b0, 32'd0, 1'b0);

    // Address wrap.
    run(16'hFFFE, 16'd3, 1'b1, mk(1, 2, 3, 4), 0, 1'b0);
    verify("wrap", 16'hFFFE, 3, 1'b1, 32'h04030201, 1'b0);

    // Empty run.
    run(16'h0500, 16'd0, 1'b1, mk(9, 9, 9, 9), 0, 1'b0);
    verify("zero", 16'h0500, 0, 1'b1, 32'd0, 1'b0);
    check("zero_in_ready_never", 32'(in_ready_seen - ib), 32'd0);
    check("zero_mem_we_never", 32'(we_seen - wb), 32'd0);

    // Reset with two words buffered.
    db = done_cnt; pb = push_cnt;
    base_addr = 16'h0600; word_count = 16'd4; start = 1'b1; in_valid = 1'b1;
    in_data = pattern(0); mem_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    in_data = pattern(1);
    step();
    in_valid = 1'b0;
    check("abort_buffered", 32'(push_cnt - pb), 32'd2);
    check("abort_we_before", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("abort_no_done", 32'(done_cnt - db), 32'd0);
    check("abort_idle_we", 32'(mem_we), 32'd0);

    // Fresh run after reset, with start pulses while busy that must be ignored.
    run(16'h0700, 16'd2, 1'b1, mk(5, 6, 7, 8), 0, 1'b1);
    verify("after_reset", 16'h0700, 2, 1'b1, 32'h08070605, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
